// File: rtl/multi_timer.sv
// multi_timer
//   Multi-channel millisecond countdown timer. Each channel owns a prescaler
//   that divides clk into ms ticks, a value counter, and a reload register.
//   Channels run one-shot (stop at 0) or auto-reload (wrap from 1 back to the
//   reload value). Every expiry gives a one-cycle pulse and a sticky done flag.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   load         per-channel load strobe (highest priority)
//   load_value   per-channel start value, channel i at [i*VW +: VW]
//   enable       per-channel count enable, low = paused (state held exactly)
//   auto_reload  per-channel mode, 0 = one-shot, 1 = periodic
//   clear_done   per-channel clear of the sticky done flag
//   timer_value  per-channel current count in ms (registered)
//   expired      per-channel one-cycle expiry pulse (registered)
//   done         per-channel sticky expiry flag (registered)
//   running      per-channel enable && value != 0 (combinational)

module multi_timer #(
  parameter int NUM_CH      = 4,
  parameter int MAX_MS      = 1000,
  parameter int CLKS_PER_MS = 50000,
  localparam int VW         = $clog2(MAX_MS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    load,
  input  logic [NUM_CH*VW-1:0] load_value,
  input  logic [NUM_CH-1:0]    enable,
  input  logic [NUM_CH-1:0]    auto_reload,
  input  logic [NUM_CH-1:0]    clear_done,
  output logic [NUM_CH*VW-1:0] timer_value,
  output logic [NUM_CH-1:0]    expired,
  output logic [NUM_CH-1:0]    done,
  output logic [NUM_CH-1:0]    running
);

  localparam int            PW       = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [VW-1:0] MAX_V    = VW'(MAX_MS);
  localparam logic [PW-1:0] PRESC_TC = PW'(CLKS_PER_MS - 1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [VW-1:0] value_q;
    logic [VW-1:0] reload_q;
    logic [PW-1:0] presc_q;
    logic          expired_q;
    logic          done_q;
    logic [VW-1:0] load_eff;
    logic          advance;
    logic          tick;
    logic          expire;

    // Requests above MAX_MS saturate rather than wrap.
    assign load_eff = (load_value[i*VW +: VW] > MAX_V) ? MAX_V : load_value[i*VW +: VW];

    // A channel sitting at 0 is idle: its prescaler is frozen too, so a later
    // enable without a load never produces a spurious tick.
    assign advance = enable[i] && (value_q != '0);
    assign tick    = advance && (presc_q == PRESC_TC);
    assign expire  = tick && (value_q == VW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        value_q   <= '0;
        reload_q  <= '0;
        presc_q   <= '0;
        expired_q <= 1'b0;
        done_q    <= 1'b0;
      end else if (load[i]) begin
        // Load overrides any tick or expiry on the same edge.
        value_q   <= load_eff;
        reload_q  <= load_eff;
        presc_q   <= '0;
        expired_q <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        expired_q <= expire;
        // An expiry on the same edge as clear_done leaves done set.
        if (expire) begin
          done_q <= 1'b1;
        end else if (clear_done[i]) begin
          done_q <= 1'b0;
        end
        if (tick) begin
          presc_q <= '0;
          if (expire) begin
            value_q <= auto_reload[i] ? reload_q : '0;
          end else begin
            value_q <= value_q - 1'b1;
          end
        end else if (advance) begin
          presc_q <= presc_q + 1'b1;
        end
      end
    end

    assign timer_value[i*VW +: VW] = value_q;
    assign expired[i]              = expired_q;
    assign done[i]                 = done_q;
    assign running[i]              = enable[i] && (value_q != '0);
  end

endmodule

// File: tb/tb_multi_timer.sv
module tb_multi_timer;

  localparam int NUM_CH      = 2;
  localparam int MAX_MS      = 16;
  localparam int CLKS_PER_MS = 10;
  localparam int VW          = $clog2(MAX_MS + 1);

  logic                 clk;
  logic                 rst_n;
  logic [NUM_CH-1:0]    load;
  logic [NUM_CH*VW-1:0] load_value;
  logic [NUM_CH-1:0]    enable;
  logic [NUM_CH-1:0]    auto_reload;
  logic [NUM_CH-1:0]    clear_done;
  logic [NUM_CH*VW-1:0] timer_value;
  logic [NUM_CH-1:0]    expired;
  logic [NUM_CH-1:0]    done;
  logic [NUM_CH-1:0]    running;

  int n_checks = 0;
  int n_pass   = 0;

  multi_timer #(
    .NUM_CH      (NUM_CH),
    .MAX_MS      (MAX_MS),
    .CLKS_PER_MS (CLKS_PER_MS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .load_value  (load_value),
    .enable      (enable),
    .auto_reload (auto_reload),
    .clear_done  (clear_done),
    .timer_value (timer_value),
    .expired     (expired),
    .done        (done),
    .running     (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int val(input int ch);
    return int'(timer_value[ch*VW +: VW]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    load        = '0;
    load_value  = '0;
    enable      = '0;
    auto_reload = '0;
    clear_done  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  // Presents a load for exactly one edge; returns 1 ns after that edge.
  task automatic load_ch(input int ch, input int v);
    load_value[ch*VW +: VW] = VW'(v);
    load[ch] = 1'b1;
    step();
    load[ch] = 1'b0;
  endtask

  initial begin
    int ev, prog, ed;

    // ---------------- reset with random inputs ----------------
    rst_n       = 1'b0;
    load        = 2'($urandom);
    load_value  = 10'($urandom);
    enable      = 2'($urandom);
    auto_reload = 2'($urandom);
    clear_done  = 2'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst timer_value", int'(timer_value), 0);
    chk("rst expired", int'(expired), 0);
    chk("rst done", int'(done), 0);
    chk("rst running", int'(running), 0);
    load   = '0;
    enable = '1;
    rst_n  = 1'b1;
    repeat (100) step();
    chk("post-rst timer_value", int'(timer_value), 0);
    chk("post-rst done", int'(done), 0);
    chk("post-rst expired", int'(expired), 0);
    chk("post-rst running", int'(running), 0);

    // ---------------- one-shot on ch0 ----------------
    do_reset();
    enable = 2'b11;
    load_ch(0, 5);
    chk("oneshot load value", val(0), 5);
    chk("oneshot running", int'(running[0]), 1);
    for (int n = 1; n <= 60; n++) begin
      step();
      ev = (n >= 50) ? 0 : 5 - n / 10;
      chk($sformatf("oneshot value n=%0d", n), val(0), ev);
      chk($sformatf("oneshot expired n=%0d", n), int'(expired[0]), (n == 50) ? 1 : 0);
      chk($sformatf("oneshot done n=%0d", n), int'(done[0]), (n >= 50) ? 1 : 0);
    end
    chk("oneshot running idle", int'(running[0]), 0);
    chk("oneshot ch1 value", val(1), 0);
    chk("oneshot ch1 expired", int'(expired[1]), 0);

    // ---------------- pause on ch0 ----------------
    // enable low is sampled on edges 23..52, so every later event slips 30 cycles.
    do_reset();
    enable = 2'b01;
    load_ch(0, 5);
    for (int n = 1; n <= 85; n++) begin
      step();
      prog = n - ((n <= 22) ? 0 : ((n >= 52) ? 30 : n - 22));
      ev   = (prog >= 50) ? 0 : 5 - prog / 10;
      chk($sformatf("pause value n=%0d", n), val(0), ev);
      chk($sformatf("pause expired n=%0d", n), int'(expired[0]), (n == 80) ? 1 : 0);
      if (n == 22) enable[0] = 1'b0;
      if (n == 52) enable[0] = 1'b1;
    end

    // ---------------- auto-reload on ch1 ----------------
    do_reset();
    enable      = 2'b10;
    auto_reload = 2'b10;
    load_ch(1, 3);
    chk("reload load value", val(1), 3);
    for (int n = 1; n <= 125; n++) begin
      step();
      ev = (n >= 120) ? 0 : 3 - (n % 30) / 10;
      ed = (n < 30) ? 0 : (n <= 40) ? 1 : (n < 60) ? 0 : 1;
      chk($sformatf("reload value n=%0d", n), val(1), ev);
      chk($sformatf("reload expired n=%0d", n), int'(expired[1]), (n % 30 == 0) ? 1 : 0);
      chk($sformatf("reload done n=%0d", n), int'(done[1]), ed);
      if (n == 40) clear_done[1] = 1'b1;
      if (n == 41) clear_done[1] = 1'b0;
      if (n == 89) clear_done[1] = 1'b1;
      if (n == 90) clear_done[1] = 1'b0;
      if (n == 95) auto_reload[1] = 1'b0;
    end
    chk("reload ch0 value", val(0), 0);

    // ---------------- saturation, reload mid-count, collision ----------------
    do_reset();
    enable = 2'b01;
    load_ch(0, 20);
    chk("sat value", val(0), 16);
    repeat (15) step();
    chk("sat count", val(0), 15);
    load_ch(0, 2);
    chk("reload-mid value", val(0), 2);
    chk("reload-mid done", int'(done[0]), 0);
    repeat (19) step();
    chk("reload-mid pre value", val(0), 1);
    chk("reload-mid pre expired", int'(expired[0]), 0);
    step();
    chk("reload-mid exp value", val(0), 0);
    chk("reload-mid exp expired", int'(expired[0]), 1);
    chk("reload-mid exp done", int'(done[0]), 1);

    auto_reload[0] = 1'b1;
    load_ch(0, 1);
    chk("coll load value", val(0), 1);
    chk("coll load done", int'(done[0]), 0);
    repeat (10) step();
    chk("coll first expired", int'(expired[0]), 1);
    chk("coll first value", val(0), 1);
    chk("coll first done", int'(done[0]), 1);
    repeat (9) step();
    chk("coll pre expired", int'(expired[0]), 0);
    chk("coll pre done", int'(done[0]), 1);
    load_ch(0, 4);
    chk("coll value", val(0), 4);
    chk("coll expired", int'(expired[0]), 0);
    chk("coll done", int'(done[0]), 0);
    step();
    chk("coll after expired", int'(expired[0]), 0);
    chk("coll after value", val(0), 4);

    // ---------------- async reset mid-count ----------------
    do_reset();
    enable = 2'b01;
    load_ch(0, 9);
    repeat (20) step();
    chk("arst pre value", val(0), 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst value", val(0), 0);
    chk("arst running", int'(running[0]), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) step();
    chk("arst idle value", val(0), 0);
    load_ch(0, 4);
    chk("arst reload value", val(0), 4);
    repeat (10) step();
    chk("arst first tick", val(0), 3);
    repeat (29) step();
    chk("arst pre-exp value", val(0), 1);
    step();
    chk("arst exp value", val(0), 0);
    chk("arst exp expired", int'(expired[0]), 1);
    chk("arst exp done", int'(done[0]), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
